// File: rtl/uart_sched_pkg.sv
// Shared state encoding, counter width and elaboration helper for the UART TX scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_e;

    localparam int WORDS_SENT_W = 16;

    // Bits needed to index 'value' items; never less than one so single-bit ids stay legal.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last winner, wrapping modulo NUM_REQ.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_req_o
);

    // Walk the candidates from farthest to nearest so the nearest set request overrides.
    always_comb begin
        winner_o = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_i[(int'(last_i) + i) % NUM_REQ]) begin
                winner_o = ID_W'((int'(last_i) + i) % NUM_REQ);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ word sources.
// Optional txDone watchdog enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 40000
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        TxBusy,
    input  logic                        txDone,
    output logic [clog2(NUM_REQ)-1:0]   grant_id,
    output logic                        sched_busy,
    output logic [WORDS_SENT_W-1:0]     words_sent,
    output logic                        timeout_err
);

    localparam int ID_W = clog2(NUM_REQ);

    sched_state_e            state_q, state_d;
    logic [ID_W-1:0]         lastId_q, lastId_d;
    logic [ID_W-1:0]         grantId_q, grantId_d;
    logic [ID_W-1:0]         winnerId;
    logic                    anyReq;
    logic [NUM_REQ-1:0]      reqReady_q, reqReady_d;
    logic                    txStart_q, txStart_d;
    logic [DATA_W-1:0]       txData_q, txData_d;
    logic [WORDS_SENT_W-1:0] wordsSent_q, wordsSent_d;
    logic                    timeoutHit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) uArbiter (
        .req_i     (req_valid),
        .last_i    (lastId_q),
        .winner_o  (winnerId),
        .any_req_o (anyReq)
    );

`ifdef UART_TX_TIMEOUT_EN
    localparam int TMR_W = (clog2(TIMEOUT_CYC) < 16) ? 16 : clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] waitCnt_q, waitCnt_d;
    logic             timeoutErr_q, timeoutErr_d;

    // The wait counter restarts while launching so it reads zero in the first WAIT_DONE cycle.
    always_comb begin
        waitCnt_d    = waitCnt_q;
        timeoutErr_d = timeoutErr_q | timeoutHit;
        if (state_q == LAUNCH) begin
            waitCnt_d = '0;
        end else if (state_q == WAIT_DONE) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            waitCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            waitCnt_q    <= waitCnt_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign timeoutHit  = (state_q == WAIT_DONE) && !txDone && (waitCnt_q == TMR_LAST);
    assign timeout_err = timeoutErr_q;
`else
    logic unusedTimeoutCfg;

    assign unusedTimeoutCfg = ^32'(TIMEOUT_CYC);
    assign timeoutHit       = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    // Grant, launch and completion decisions; a txDone wins over an expiring watchdog.
    always_comb begin
        state_d     = state_q;
        lastId_d    = lastId_q;
        grantId_d   = grantId_q;
        reqReady_d  = '0;
        txStart_d   = 1'b0;
        txData_d    = txData_q;
        wordsSent_d = wordsSent_q;
        case (state_q)
            IDLE: begin
                if (anyReq && !TxBusy) begin
                    state_d              = LAUNCH;
                    lastId_d             = winnerId;
                    grantId_d            = winnerId;
                    reqReady_d[winnerId] = 1'b1;
                    txData_d             = req_data[winnerId*DATA_W +: DATA_W];
                end
            end
            LAUNCH: begin
                txStart_d = 1'b1;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (txDone) begin
                    wordsSent_d = wordsSent_q + 1'b1;
                    state_d     = IDLE;
                end else if (timeoutHit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer resets to the last requester so requester 0 has first priority.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            lastId_q    <= ID_W'(NUM_REQ - 1);
            grantId_q   <= '0;
            reqReady_q  <= '0;
            txStart_q   <= 1'b0;
            txData_q    <= '0;
            wordsSent_q <= '0;
        end else begin
            state_q     <= state_d;
            lastId_q    <= lastId_d;
            grantId_q   <= grantId_d;
            reqReady_q  <= reqReady_d;
            txStart_q   <= txStart_d;
            txData_q    <= txData_d;
            wordsSent_q <= wordsSent_d;
        end
    end

    assign req_ready  = reqReady_q;
    assign tx_start   = txStart_q;
    assign tx_data    = txData_q;
    assign grant_id   = grantId_q;
    assign sched_busy = (state_q != IDLE);
    assign words_sent = wordsSent_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler; exercises the watchdog when UART_TX_TIMEOUT_EN is defined.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
`ifdef UART_TX_TIMEOUT_EN
    localparam int TO_CYC = 100;
`else
    localparam int TO_CYC = 40000;
`endif

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic                      PCLK = 1'b0;
    logic                      PRESET = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      TxBusy = 1'b0;
    logic                      txDone = 1'b0;
    logic                      grant_id;
    logic                      sched_busy;
    logic [15:0]               words_sent;
    logic                      timeout_err;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails = 0;

    uart_tx_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .TxBusy      (TxBusy),
        .txDone      (txDone),
        .grant_id    (grant_id),
        .sched_busy  (sched_busy),
        .words_sent  (words_sent),
        .timeout_err (timeout_err)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] d0, input logic [31:0] d1);
        req_valid = valid;
        req_data  = {d1, d0};
    endtask

    task automatic doReset();
        PRESET = 1'b1;
        TxBusy = 1'b0;
        txDone = 1'b0;
        applyStimulus(2'b00, 32'h0, 32'h0);
        expQ.delete();
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic pulseTxDone();
        txDone = 1'b1;
        @(negedge PCLK);
        txDone = 1'b0;
    endtask

    task automatic waitTxStart(input int budget, output bit seen, output int waited,
                               output logic gid, output logic [31:0] data);
        seen   = 1'b0;
        waited = 0;
        gid    = 1'b0;
        data   = '0;
        while (!seen && waited < budget) begin
            @(negedge PCLK);
            waited++;
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                gid  = grant_id;
                data = tx_data;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge PCLK);
        nChecks++;
        if ({req_ready, tx_start, tx_data, grant_id} !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got ready=%b start=%b data=%h id=%b expected all zero",
                     req_ready, tx_start, tx_data, grant_id);
        end
        nChecks++;
        if ({words_sent, timeout_err, sched_busy} !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_status: got words=%h err=%b busy=%b expected all zero",
                     words_sent, timeout_err, sched_busy);
        end
    endtask

    task automatic test_single();
        bit seen; int waited; logic gid; logic [31:0] data; exp_t e;
        doReset();
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0);
        expQ.push_back('{id: 1'b0, data: 32'hFFFF_FFFF});
        @(negedge PCLK);
        nChecks++;
        if (req_ready !== 2'b01 || tx_start !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL single_ready: got ready=%b start=%b expected ready=01 start=0", req_ready, tx_start);
        end
        applyStimulus(2'b00, 32'h0, 32'h0);
        waitTxStart(5, seen, waited, gid, data);
        e = expQ.pop_front();
        nChecks++;
        if (!seen || waited != 1 || {gid, data} !== {e.id, e.data}) begin
            nFails++;
            $display("[TB] FAIL single_launch: got seen=%0d wait=%0d id=%b data=%h expected wait=1 id=%b data=%h",
                     seen, waited, gid, data, e.id, e.data);
        end
        @(negedge PCLK);
        nChecks++;
        if (req_ready !== 2'b00 || tx_start !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL single_pulses: got ready=%b start=%b expected 00 and 0", req_ready, tx_start);
        end
        pulseTxDone();
        nChecks++;
        if (words_sent !== 16'd1 || sched_busy !== 1'b0 || tx_data !== 32'hFFFF_FFFF) begin
            nFails++;
            $display("[TB] FAIL single_done: got words=%0d busy=%b data=%h expected 1, 0, ffffffff",
                     words_sent, sched_busy, tx_data);
        end
    endtask

    task automatic test_round_robin();
        bit seen; int waited; logic gid; logic [31:0] data; exp_t e;
        doReset();
        applyStimulus(2'b11, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) expQ.push_back('{id: 1'b0, data: 32'hA5A5_A5A5});
            else            expQ.push_back('{id: 1'b1, data: 32'h5A5A_5A5A});
        end
        for (int k = 0; k < 4; k++) begin
            waitTxStart(10, seen, waited, gid, data);
            e = expQ.pop_front();
            nChecks++;
            if (!seen || {gid, data} !== {e.id, e.data}) begin
                nFails++;
                $display("[TB] FAIL rr_frame%0d: got seen=%0d id=%b data=%h expected id=%b data=%h",
                         k, seen, gid, data, e.id, e.data);
            end
            pulseTxDone();
        end
        applyStimulus(2'b00, 32'h0, 32'h0);
        nChecks++;
        if (words_sent !== 16'd4) begin
            nFails++;
            $display("[TB] FAIL rr_count: got %0d expected 4", words_sent);
        end
    endtask

    task automatic test_txbusy_hold();
        bit seen; int waited; logic gid; logic [31:0] data; exp_t e; int stray;
        doReset();
        TxBusy = 1'b1;
        applyStimulus(2'b10, 32'h0, 32'h1234_5678);
        expQ.push_back('{id: 1'b1, data: 32'h1234_5678});
        stray = 0;
        repeat (50) begin
            @(negedge PCLK);
            if (req_ready !== 2'b00 || sched_busy !== 1'b0) stray++;
        end
        nChecks++;
        if (stray != 0) begin
            nFails++;
            $display("[TB] FAIL busy_hold: got %0d grant cycles while TxBusy expected 0", stray);
        end
        TxBusy = 1'b0;
        @(negedge PCLK);
        nChecks++;
        if (req_ready !== 2'b10 || grant_id !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL busy_release: got ready=%b id=%b expected 10 and 1", req_ready, grant_id);
        end
        applyStimulus(2'b00, 32'h0, 32'h0);
        waitTxStart(5, seen, waited, gid, data);
        e = expQ.pop_front();
        nChecks++;
        if (!seen || {gid, data} !== {e.id, e.data}) begin
            nFails++;
            $display("[TB] FAIL busy_launch: got seen=%0d id=%b data=%h expected id=%b data=%h",
                     seen, gid, data, e.id, e.data);
        end
        pulseTxDone();
    endtask

    task automatic test_reset_mid_frame();
        bit seen; int waited; logic gid; logic [31:0] data; exp_t e;
        doReset();
        applyStimulus(2'b10, 32'h0, 32'h0BAD_BEEF);
        @(negedge PCLK);
        applyStimulus(2'b00, 32'h0, 32'h0);
        waitTxStart(5, seen, waited, gid, data);
        pulseTxDone();
        applyStimulus(2'b01, 32'hCAFE_F00D, 32'h0);
        @(negedge PCLK);
        applyStimulus(2'b00, 32'h0, 32'h0);
        waitTxStart(5, seen, waited, gid, data);
        #2 PRESET = 1'b1;
        #1;
        nChecks++;
        if ({req_ready, tx_start, tx_data, grant_id, words_sent, timeout_err, sched_busy} !== '0) begin
            nFails++;
            $display("[TB] FAIL async_reset: got ready=%b start=%b data=%h id=%b words=%0d err=%b busy=%b expected all zero",
                     req_ready, tx_start, tx_data, grant_id, words_sent, timeout_err, sched_busy);
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        expQ.delete();
        applyStimulus(2'b11, 32'h1111_0000, 32'h2222_0000);
        expQ.push_back('{id: 1'b0, data: 32'h1111_0000});
        @(negedge PCLK);
        nChecks++;
        if (req_ready !== 2'b01 || grant_id !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_pointer: got ready=%b id=%b expected 01 and 0", req_ready, grant_id);
        end
        applyStimulus(2'b00, 32'h0, 32'h0);
        waitTxStart(5, seen, waited, gid, data);
        e = expQ.pop_front();
        nChecks++;
        if (!seen || {gid, data} !== {e.id, e.data}) begin
            nFails++;
            $display("[TB] FAIL reset_relaunch: got seen=%0d id=%b data=%h expected id=%b data=%h",
                     seen, gid, data, e.id, e.data);
        end
        pulseTxDone();
    endtask

    task automatic test_timeout();
        bit seen; int waited; logic gid; logic [31:0] data;
        doReset();
        applyStimulus(2'b01, 32'h7777_7777, 32'h0);
        @(negedge PCLK);
        applyStimulus(2'b00, 32'h0, 32'h0);
        waitTxStart(5, seen, waited, gid, data);
`ifdef UART_TX_TIMEOUT_EN
        repeat (TO_CYC - 1) @(negedge PCLK);
        nChecks++;
        if (timeout_err !== 1'b0 || sched_busy !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL timeout_early: got err=%b busy=%b expected 0 and 1", timeout_err, sched_busy);
        end
        @(negedge PCLK);
        nChecks++;
        if (timeout_err !== 1'b1 || sched_busy !== 1'b0 || words_sent !== 16'd0) begin
            nFails++;
            $display("[TB] FAIL timeout_expire: got err=%b busy=%b words=%0d expected 1, 0, 0",
                     timeout_err, sched_busy, words_sent);
        end
`else
        repeat (150) @(negedge PCLK);
        nChecks++;
        if (timeout_err !== 1'b0 || sched_busy !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL no_timeout_wait: got err=%b busy=%b expected 0 and 1", timeout_err, sched_busy);
        end
        pulseTxDone();
        nChecks++;
        if (words_sent !== 16'd1 || sched_busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL no_timeout_done: got words=%0d busy=%b expected 1 and 0", words_sent, sched_busy);
        end
`endif
    endtask

    task automatic test_back_to_back();
        bit seen; int waited; logic gid; logic [31:0] data; exp_t e;
        doReset();
        applyStimulus(2'b01, 32'h1111_1111, 32'h0);
        expQ.push_back('{id: 1'b0, data: 32'h1111_1111});
        @(negedge PCLK);
        applyStimulus(2'b00, 32'h0, 32'h0);
        waitTxStart(5, seen, waited, gid, data);
        e = expQ.pop_front();
        nChecks++;
        if (!seen || {gid, data} !== {e.id, e.data}) begin
            nFails++;
            $display("[TB] FAIL b2b_first: got seen=%0d id=%b data=%h expected id=%b data=%h",
                     seen, gid, data, e.id, e.data);
        end
        txDone = 1'b1;
        applyStimulus(2'b01, 32'h2222_2222, 32'h0);
        expQ.push_back('{id: 1'b0, data: 32'h2222_2222});
        @(negedge PCLK);
        txDone = 1'b0;
        nChecks++;
        if (req_ready !== 2'b00 || sched_busy !== 1'b0 || words_sent !== 16'd1) begin
            nFails++;
            $display("[TB] FAIL b2b_idle: got ready=%b busy=%b words=%0d expected 00, 0, 1",
                     req_ready, sched_busy, words_sent);
        end
        @(negedge PCLK);
        nChecks++;
        if (req_ready !== 2'b01) begin
            nFails++;
            $display("[TB] FAIL b2b_grant: got ready=%b expected 01", req_ready);
        end
        applyStimulus(2'b00, 32'h0, 32'h0);
        waitTxStart(5, seen, waited, gid, data);
        e = expQ.pop_front();
        nChecks++;
        if (!seen || {gid, data} !== {e.id, e.data}) begin
            nFails++;
            $display("[TB] FAIL b2b_second: got seen=%0d id=%b data=%h expected id=%b data=%h",
                     seen, gid, data, e.id, e.data);
        end
        force dut.wordsSent_q = 16'hFFFF;
        @(negedge PCLK);
        release dut.wordsSent_q;
        pulseTxDone();
        nChecks++;
        if (words_sent !== 16'h0000 || sched_busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL words_wrap: got words=%h busy=%b expected 0000 and 0", words_sent, sched_busy);
        end
    endtask

    initial begin
        $display("[TB] uart_tx_scheduler bench starting");
        test_reset();
        test_single();
        test_round_robin();
        test_txbusy_hold();
        test_reset_mid_frame();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
